// File: rtl/adder_pkg.sv
// Shared definitions for the byte-serial adder slice: word width and sequencer states.
package adder_pkg;

   localparam int WORD_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/wide_add_seq_if.sv
// Request/result handshake bundle for wide_add_seq; master = requester/consumer, slave = sequencer.
interface wide_add_seq_if
   import adder_pkg::*;
#(
   parameter int WORDS = 4
);
   logic                      in_valid;
   logic                      in_ready;
   logic [WORDS*WORD_W-1:0]   a_in;
   logic [WORDS*WORD_W-1:0]   b_in;
   logic                      cin;
   logic                      sub;
   logic                      out_valid;
   logic                      out_ready;
   logic [WORDS*WORD_W-1:0]   sum_out;
   logic                      cout_out;
   logic                      ovf_out;

   modport master (
      output in_valid, a_in, b_in, cin, sub, out_ready,
      input  in_ready, out_valid, sum_out, cout_out, ovf_out
   );

   modport slave (
      input  in_valid, a_in, b_in, cin, sub, out_ready,
      output in_ready, out_valid, sum_out, cout_out, ovf_out
   );

endinterface

// File: rtl/wide_add_seq_ripplemod.sv
// 8-bit ripple-carry adder (ripplemod), purely combinational.
// Latency: 0 cycles. Backpressure: none.
module ripplemod
   import adder_pkg::*;
(
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              ci,
   output logic [WORD_W-1:0] s,
   output logic              co
);
   logic carry;

   always_comb begin
      carry = ci;
      s     = '0;
      for (int i = 0; i < WORD_W; i++) begin
         s[i]  = a[i] ^ b[i] ^ carry;
         carry = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
      end
      co = carry;
   end

endmodule

// File: rtl/wide_add_seq.sv
// Multi-word add/sub sequencer: one shared 8-bit ripple adder, LSB word first, carry registered.
// Latency: out_valid WORDS+1 cycles after accept; one request per WORDS+2 cycles.
// Backpressure: result held until out_ready; in_ready low whenever not IDLE, nothing queued.
module wide_add_seq
   import adder_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   wide_add_seq_if.slave  bus
);
   localparam int W  = WORDS * WORD_W;
   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt;
   logic [W-1:0]      a_reg, b_reg, sum_reg;
   logic              carry_reg, cout_reg, ovf_reg;
   logic [WORD_W-1:0] a_w, b_w, s_w;
   logic              co_w;
   logic              accept;

   assign bus.in_ready  = (state == ST_IDLE);
   assign bus.out_valid = (state == ST_DONE);
   assign bus.sum_out   = sum_reg;
   assign bus.cout_out  = cout_reg;
   assign bus.ovf_out   = ovf_reg;
   assign accept        = bus.in_valid && bus.in_ready;

   // Word mux feeding the shared adder.
   always_comb begin
      a_w = '0;
      b_w = '0;
      for (int k = 0; k < WORDS; k++) begin
         if (cnt == CW'(k)) begin
            a_w = a_reg[k*WORD_W +: WORD_W];
            b_w = b_reg[k*WORD_W +: WORD_W];
         end
      end
   end

   ripplemod u_add (
      .a  (a_w),
      .b  (b_w),
      .ci (carry_reg),
      .s  (s_w),
      .co (co_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept)        state_nxt = ST_RUN;
         ST_RUN:  if (cnt == LAST)   state_nxt = ST_DONE;
         ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
         default:                    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else if (accept) begin
         // Subtract is A + ~B + 1, so cin is overridden.
         a_reg     <= bus.a_in;
         b_reg     <= bus.b_in ^ {W{bus.sub}};
         carry_reg <= bus.sub | bus.cin;
         cnt       <= '0;
      end else if (state == ST_RUN) begin
         for (int k = 0; k < WORDS; k++) begin
            if (cnt == CW'(k)) sum_reg[k*WORD_W +: WORD_W] <= s_w;
         end
         carry_reg <= co_w;
         if (cnt == LAST) begin
            cnt      <= '0;
            cout_reg <= co_w;
            ovf_reg  <= a_w[WORD_W-1] ^ b_w[WORD_W-1] ^ s_w[WORD_W-1] ^ co_w;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq (WORDS=4): add, subtract, hold under backpressure, reset abort.
module tb_wide_add_seq;
   localparam int WORDS = 4;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;
   int   lat;

   wide_add_seq_if #(.WORDS(WORDS)) bus ();

   wide_add_seq #(.WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic s);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.a_in      = a;
      bus.b_in      = b;
      bus.cin       = ci;
      bus.sub       = s;
      bus.out_ready = 1'b1;
   endtask

   // Counts edges from the accept edge (=1) until out_valid; scrambles inputs after accept.
   task automatic wait_valid(input string tag, output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) begin
            chk({tag, "_busy"}, {63'd0, bus.in_ready}, 64'd0);
            bus.in_valid = 1'b0;
            bus.a_in     = 32'hDEAD_BEEF;
            bus.b_in     = 32'hCAFE_F00D;
            bus.cin      = ~bus.cin;
            bus.sub      = ~bus.sub;
         end
      end while (!bus.out_valid && n < 20);
      chk({tag, "_lat"}, 64'(n), 64'd5);
   endtask

   task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic ci, input logic s,
                     input logic [31:0] es, input logic ec, input logic eo);
      int n;
      send(a, b, ci, s);
      wait_valid(tag, n);
      chk({tag, "_sum"},  64'(bus.sum_out), 64'(es));
      chk({tag, "_cout"}, {63'd0, bus.cout_out}, {63'd0, ec});
      chk({tag, "_ovf"},  {63'd0, bus.ovf_out},  {63'd0, eo});
      @(posedge clk);
      #1;
      chk({tag, "_idle"}, {63'd0, bus.in_ready}, 64'd1);
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a_in      = '0;
      bus.b_in      = '0;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdy_during", {63'd0, bus.in_ready}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_rdy",  {63'd0, bus.in_ready},  64'd1);
      chk("rst_vld",  {63'd0, bus.out_valid}, 64'd0);
      chk("rst_sum",  64'(bus.sum_out),       64'd0);
      chk("rst_cout", {63'd0, bus.cout_out},  64'd0);
      chk("rst_ovf",  {63'd0, bus.ovf_out},   64'd0);

      // Carry across word boundary, full carry chain, signed overflow
      op("add_ff",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
      op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

      // Subtract: borrow and signed overflow
      op("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

      // Backpressure: result held, new requests ignored
      send(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0);
      bus.out_ready = 1'b0;
      wait_valid("hold", lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.a_in     = $urandom;
         bus.b_in     = $urandom;
         @(posedge clk);
         #1;
         chk("hold_sum", 64'(bus.sum_out), 64'h1122_3344);
         chk("hold_vld", {63'd0, bus.out_valid}, 64'd1);
         chk("hold_rdy", {63'd0, bus.in_ready},  64'd0);
      end
      chk("hold_cout", {63'd0, bus.cout_out}, 64'd0);
      chk("hold_ovf",  {63'd0, bus.ovf_out},  64'd0);
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.a_in      = 32'h0000_0003;
      bus.b_in      = 32'h0000_0004;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      @(posedge clk);
      #1;
      chk("rel_vld", {63'd0, bus.out_valid}, 64'd0);
      chk("rel_rdy", {63'd0, bus.in_ready},  64'd1);
      wait_valid("post", lat);
      chk("post_sum", 64'(bus.sum_out), 64'd7);
      @(posedge clk);
      #1;

      // Reset abort during word 2
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_vld", {63'd0, bus.out_valid}, 64'd0);
      chk("abort_rdy", {63'd0, bus.in_ready},  64'd1);
      chk("abort_sum", 64'(bus.sum_out),       64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      lat = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) lat++;
      end
      chk("abort_nopulse", 64'(lat), 64'd0);
      op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
